// File: rtl/rca_lsq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rca_lsq_if
//  Description : OU-side request/response and data-memory port bundle of the
//                RCA load/store queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rca_lsq_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
    logic            new_request;
    logic            lsq_full;
    logic [XLEN-1:0] load_data;
    logic            load_complete;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_we;
    logic            mem_req;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rvalid;

    modport slave (
        input  addr, data, fn3, load, store, new_request,
        input  mem_ack, mem_rdata, mem_rvalid,
        output lsq_full, load_data, load_complete,
        output mem_addr, mem_wdata, mem_be, mem_we, mem_req
    );

    modport master (
        output addr, data, fn3, load, store, new_request,
        output mem_ack, mem_rdata, mem_rvalid,
        input  lsq_full, load_data, load_complete,
        input  mem_addr, mem_wdata, mem_be, mem_we, mem_req
    );
endinterface
`default_nettype wire

// File: rtl/rca_lsq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rca_lsq
//  Description : In-order load/store queue for RCA operation units; issues one
//                word-wide memory transaction at a time, returns extended loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_lsq #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rca_lsq_if.slave   lsq
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    logic [XLEN-1:0]    r_q_addr [DEPTH];
    logic [XLEN-1:0]    r_q_data [DEPTH];
    logic [2:0]         r_q_fn3  [DEPTH];
    logic               r_q_load [DEPTH];

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_state;
    logic [XLEN-1:0]    r_load_data;
    logic               r_load_complete;

    logic               w_full;
    logic               w_enq;
    logic               w_deq;
    logic               w_load_done;
    logic [1:0]         w_next_state;
    logic [XLEN-1:0]    w_head_addr;
    logic [XLEN-1:0]    w_head_data;
    logic [2:0]         w_head_fn3;
    logic               w_head_load;
    logic [1:0]         w_off;
    logic [3:0]         w_be;
    logic [XLEN-1:0]    w_wdata;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [XLEN-1:0]    w_ext_data;

    assign w_full      = (r_count == c_CNT_W'(DEPTH));
    assign w_enq       = lsq.new_request && !w_full && (lsq.load || lsq.store);

    assign w_head_addr = r_q_addr[r_head];
    assign w_head_data = r_q_data[r_head];
    assign w_head_fn3  = r_q_fn3[r_head];
    assign w_head_load = r_q_load[r_head];
    assign w_off       = w_head_addr[1:0];

    // A load accepted together with its data retires in the same cycle as a store would
    assign w_deq = ((r_state == c_ST_REQ) && lsq.mem_ack && (!w_head_load || lsq.mem_rvalid))
                || ((r_state == c_ST_WAIT) && lsq.mem_rvalid);
    assign w_load_done  = w_deq && w_head_load;
    assign w_next_state = (r_count > c_CNT_W'(1)) ? c_ST_REQ : c_ST_IDLE;

    always_comb begin
        w_be    = 4'hF;
        w_wdata = w_head_data;
        if (!w_head_load) begin
            case (w_head_fn3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{w_head_data[7:0]}};
                end
                2'b01: begin
                    w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{w_head_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign w_byte = lsq.mem_rdata[{w_off, 3'b000} +: 8];
    assign w_half = lsq.mem_rdata[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        case (w_head_fn3)
            3'b000:  w_ext_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext_data = {24'd0, w_byte};
            3'b001:  w_ext_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext_data = {16'd0, w_half};
            default: w_ext_data = lsq.mem_rdata;
        endcase
    end

    // Entry storage needs no reset: validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_addr[r_tail] <= lsq.addr;
            r_q_data[r_tail] <= lsq.data;
            r_q_fn3[r_tail]  <= lsq.fn3;
            r_q_load[r_tail] <= lsq.load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_state         <= c_ST_IDLE;
            r_load_data     <= '0;
            r_load_complete <= 1'b0;
        end else begin
            r_load_complete <= 1'b0;
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_load_done) begin
                r_load_data     <= w_ext_data;
                r_load_complete <= 1'b1;
            end
            case (r_state)
                c_ST_IDLE: if (r_count != '0) r_state <= c_ST_REQ;
                c_ST_REQ: begin
                    if (w_deq)            r_state <= w_next_state;
                    else if (lsq.mem_ack) r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: if (w_deq) r_state <= w_next_state;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign lsq.lsq_full      = w_full;
    assign lsq.load_data     = r_load_data;
    assign lsq.load_complete = r_load_complete;
    assign lsq.mem_req       = (r_state == c_ST_REQ);
    assign lsq.mem_addr      = {w_head_addr[XLEN-1:2], 2'b00};
    assign lsq.mem_we        = !w_head_load;
    assign lsq.mem_be        = w_be;
    assign lsq.mem_wdata     = w_wdata;
endmodule
`default_nettype wire

// File: tb/tb_rca_lsq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rca_lsq
//  Description : Directed bench for rca_lsq with a queue-based reference model
//                and a per-cycle compare process.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_lsq;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rca_lsq_if #(.XLEN(XLEN)) bus ();
    rca_lsq #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .lsq(bus));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  fn3;
        logic        is_load;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t        mq[$];
    logic        m_wait   = 1'b0;
    logic        exp_lc   = 1'b0;
    logic [31:0] exp_ld   = '0;
    logic        model_on = 1'b0;
    int          lc_count = 0;
    logic [31:0] acked_addr[$];
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;

    logic [31:0] mem_words [int];
    int   ack_delay = 0;
    int   rv_delay  = 0;
    logic ack_hold  = 1'b0;
    logic rv_hold   = 1'b0;
    logic resp_en   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_true(input string name, input logic ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: condition false, expected true @%0t", name, $time);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        return mem_words.exists(idx) ? mem_words[idx] : 32'h0;
    endfunction

    function automatic logic [3:0] exp_be(input ent_t e);
        if (e.is_load) return 4'hF;
        case (e.fn3)
            3'b000, 3'b100: return 4'(1 << e.addr[1:0]);
            3'b001, 3'b101: return e.addr[1] ? 4'b1100 : 4'b0011;
            default:        return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input ent_t e);
        case (e.fn3)
            3'b000, 3'b100: return {4{e.data[7:0]}};
            3'b001, 3'b101: return {2{e.data[15:0]}};
            default:        return e.data;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input ent_t e, input logic [31:0] w);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = w >> (8 * int'(e.addr[1:0]));
        sh = w >> (16 * int'(e.addr[1]));
        case (e.fn3)
            3'b000:  return 32'($signed(sb[7:0]));
            3'b100:  return {24'd0, sb[7:0]};
            3'b001:  return 32'($signed(sh[15:0]));
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Reference model and per-cycle comparison, evaluated mid-cycle
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_be;
    logic        prev_we;
    always @(negedge clk) begin
        ent_t e;
        logic full_now;
        if (rst) begin
            mq.delete();
            m_wait     = 1'b0;
            exp_lc     = 1'b0;
            exp_ld     = '0;
            prev_stall = 1'b0;
            model_on   = 1'b1;
        end else if (model_on) begin
            full_now = (mq.size() == DEPTH);
            check("lsq_full", 32'(bus.lsq_full), 32'(full_now));
            check("load_complete", 32'(bus.load_complete), 32'(exp_lc));
            check("load_data", bus.load_data, exp_ld);
            if (bus.load_complete) lc_count++;
            if (m_wait) check("req_in_wait", 32'(bus.mem_req), 32'd0);
            if (prev_stall) begin
                check("req_held", 32'(bus.mem_req), 32'd1);
                check("hold_addr", bus.mem_addr, prev_addr);
                check("hold_we", 32'(bus.mem_we), 32'(prev_we));
                check("hold_be", 32'(bus.mem_be), 32'(prev_be));
                check("hold_wdata", bus.mem_wdata, prev_wdata);
            end
            if (bus.mem_req) begin
                expect_true("req_has_entry", mq.size() != 0 && !m_wait);
                if (mq.size() != 0) begin
                    e = mq[0];
                    check("mem_addr", bus.mem_addr, {e.addr[31:2], 2'b00});
                    check("mem_we", 32'(bus.mem_we), 32'(!e.is_load));
                    check("mem_be", 32'(bus.mem_be), 32'(exp_be(e)));
                    if (!e.is_load) check("mem_wdata", bus.mem_wdata, exp_wdata(e));
                end
                last_addr  = bus.mem_addr;
                last_wdata = bus.mem_wdata;
                last_be    = bus.mem_be;
                last_we    = bus.mem_we;
            end
            prev_stall = bus.mem_req && !bus.mem_ack;
            prev_addr  = bus.mem_addr;
            prev_wdata = bus.mem_wdata;
            prev_be    = bus.mem_be;
            prev_we    = bus.mem_we;

            exp_lc = 1'b0;
            if (bus.mem_req && bus.mem_ack && mq.size() != 0) begin
                acked_addr.push_back(bus.mem_addr);
                if (!mq[0].is_load) begin
                    void'(mq.pop_front());
                end else if (bus.mem_rvalid) begin
                    exp_ld = exp_load(mq[0], bus.mem_rdata);
                    exp_lc = 1'b1;
                    void'(mq.pop_front());
                end else begin
                    m_wait = 1'b1;
                end
            end else if (m_wait && bus.mem_rvalid) begin
                exp_ld = exp_load(mq[0], bus.mem_rdata);
                exp_lc = 1'b1;
                void'(mq.pop_front());
                m_wait = 1'b0;
            end
            if (bus.new_request && !full_now && (bus.load || bus.store)) begin
                e.addr    = bus.addr;
                e.data    = bus.data;
                e.fn3     = bus.fn3;
                e.is_load = bus.load;
                mq.push_back(e);
            end
        end
    end

    // Memory responder: ack after ack_delay request cycles, read data rv_delay cycles after ack
    int          ack_cnt = 0;
    int          rv_cnt  = 0;
    logic [31:0] rv_word = '0;
    initial begin
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk); #2;
            if (resp_en) begin
                bus.mem_ack    = 1'b0;
                bus.mem_rvalid = 1'b0;
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0 && !rv_hold) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = rv_word;
                    end
                end
                if (bus.mem_req && !ack_hold) begin
                    if (ack_cnt >= ack_delay) begin
                        ack_cnt     = 0;
                        bus.mem_ack = 1'b1;
                        if (!bus.mem_we) begin
                            rv_word = mem_read(bus.mem_addr);
                            if (rv_delay == 0) begin
                                if (!rv_hold) begin
                                    bus.mem_rvalid = 1'b1;
                                    bus.mem_rdata  = rv_word;
                                end
                            end else begin
                                rv_cnt = rv_delay;
                            end
                        end
                    end else begin
                        ack_cnt++;
                    end
                end
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        bus.new_request = 1'b1;
        bus.load        = ld;
        bus.store       = st;
        bus.fn3         = f;
        bus.addr        = a;
        bus.data        = d;
        @(posedge clk); #2;
        bus.new_request = 1'b0;
        bus.load        = 1'b0;
        bus.store       = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #2;
            if (mq.size() == 0 && !m_wait) done = 1'b1;
        end
        expect_true(name, done);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "tb_rca_lsq aborted");
    end

    initial begin
        int lc0;
        logic hit;
        bus.new_request = 1'b0;
        bus.load        = 1'b0;
        bus.store       = 1'b0;
        bus.fn3         = 3'b000;
        bus.addr        = '0;
        bus.data        = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check("rst_lsq_full", 32'(bus.lsq_full), 32'd0);
        check("rst_load_complete", 32'(bus.load_complete), 32'd0);
        check("rst_load_data", bus.load_data, 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);

        // 1: LW, ack immediately, data two cycles later
        mem_words[32'h100 >> 2] = 32'hDEAD_BEEF;
        ack_delay = 0; rv_delay = 2; lc0 = lc_count;
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        wait_idle("t1_timeout", 30);
        check("t1_load_data", bus.load_data, 32'hDEAD_BEEF);
        check("t1_pulses", 32'(lc_count - lc0), 32'd1);

        // 2: LB / LBU from the top byte lane
        mem_words[32'h100 >> 2] = 32'h80FF_0000;
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
        wait_idle("t2a_timeout", 30);
        check("t2_mem_addr", last_addr, 32'h100);
        check("t2_lb", bus.load_data, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
        wait_idle("t2b_timeout", 30);
        check("t2_lbu", bus.load_data, 32'h0000_0080);

        // 3: SH to upper half
        lc0 = lc_count;
        issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_1234);
        wait_idle("t3_timeout", 30);
        check("t3_be", 32'(last_be), 32'hC);
        check("t3_wdata", last_wdata, 32'h1234_1234);
        check("t3_we", 32'(last_we), 32'd1);
        check("t3_no_resp", 32'(lc_count - lc0), 32'd0);

        // 4: fill with memory stalled, fifth request dropped
        ack_hold = 1'b1; acked_addr.delete();
        issue(1'b0, 1'b1, 3'b010, 32'h300, 32'h1111_1111);
        issue(1'b0, 1'b1, 3'b000, 32'h305, 32'h0000_0022);
        issue(1'b0, 1'b1, 3'b001, 32'h30A, 32'h0000_3333);
        issue(1'b0, 1'b1, 3'b010, 32'h30C, 32'h4444_4444);
        check("t4_full", 32'(bus.lsq_full), 32'd1);
        issue(1'b0, 1'b1, 3'b010, 32'h3F0, 32'h5555_5555);
        repeat (3) @(posedge clk);
        #2;
        ack_hold = 1'b0;
        wait_idle("t4_timeout", 60);
        check("t4_count", 32'(acked_addr.size()), 32'd4);
        if (acked_addr.size() == 4) begin
            check("t4_order0", acked_addr[0], 32'h300);
            check("t4_order1", acked_addr[1], 32'h304);
            check("t4_order2", acked_addr[2], 32'h308);
            check("t4_order3", acked_addr[3], 32'h30C);
        end

        // 5: SW, LW, SB back to back with slow ack
        ack_delay = 3; rv_delay = 1; acked_addr.delete();
        mem_words[32'h404 >> 2] = 32'h0BAD_C0DE;
        issue(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D);
        issue(1'b1, 1'b0, 3'b010, 32'h404, 32'h0);
        issue(1'b0, 1'b1, 3'b000, 32'h409, 32'h0000_005A);
        wait_idle("t5_timeout", 80);
        check("t5_count", 32'(acked_addr.size()), 32'd3);
        if (acked_addr.size() == 3) begin
            check("t5_order0", acked_addr[0], 32'h400);
            check("t5_order1", acked_addr[1], 32'h404);
            check("t5_order2", acked_addr[2], 32'h408);
        end
        check("t5_load", bus.load_data, 32'h0BAD_C0DE);
        check("t5_sb_be", 32'(last_be), 32'h2);
        check("t5_sb_wdata", last_wdata, 32'h5A5A_5A5A);

        // 7: halfword loads, unknown fn3, load+store, ignored strobe; data with ack
        ack_delay = 1; rv_delay = 0; lc0 = lc_count;
        mem_words[32'h600 >> 2] = 32'h8001_7FFF;
        issue(1'b1, 1'b0, 3'b001, 32'h602, 32'h0);
        issue(1'b1, 1'b0, 3'b101, 32'h602, 32'h0);
        issue(1'b1, 1'b0, 3'b001, 32'h600, 32'h0);
        issue(1'b1, 1'b0, 3'b000, 32'h601, 32'h0);
        issue(1'b0, 1'b0, 3'b010, 32'h600, 32'h0);
        wait_idle("t7a_timeout", 80);
        check("t7_lb", bus.load_data, 32'h0000_007F);
        issue(1'b1, 1'b0, 3'b110, 32'h603, 32'h0);
        issue(1'b1, 1'b1, 3'b010, 32'h600, 32'hFFFF_FFFF);
        wait_idle("t7b_timeout", 80);
        check("t7_ldst", bus.load_data, 32'h8001_7FFF);
        check("t7_pulses", 32'(lc_count - lc0), 32'd6);

        // 6: reset while waiting for read data, then late rvalid
        ack_delay = 0; rv_hold = 1'b1; lc0 = lc_count;
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk); #2;
            if (m_wait) hit = 1'b1;
        end
        expect_true("t6_reach_wait", hit);
        resp_en        = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_1111;
        @(posedge clk); #2;
        bus.mem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("t6_full", 32'(bus.lsq_full), 32'd0);
        check("t6_mem_req", 32'(bus.mem_req), 32'd0);
        check("t6_no_resp", 32'(lc_count - lc0), 32'd0);
        check("t6_load_data", bus.load_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
